// File: rtl/hpel_pkg.sv
// Shared constants for the half-pel interpolation engine: filter taps,
// rounding constants, result-stream index map and the job FSM state type.
// No ports; imported by hpel_interp_engine and tap6_filter.
package hpel_pkg;

    // Six-tap half-pel filter coefficients, applied oldest-to-newest sample.
    localparam int TAPS [6] = '{1, -5, 20, 20, -5, 1};

    // Single-pass results carry a gain of 32, two-pass results a gain of 1024.
    localparam int RND_H = 16;
    localparam int SH_H  = 5;
    localparam int RND_D = 512;
    localparam int SH_D  = 10;

    // pel_idx = 3*(dy+1) + (dx+1), dx/dy in half-pel steps {-1,0,+1}.
    localparam logic [3:0] IDX_UL = 4'd0;
    localparam logic [3:0] IDX_U  = 4'd1;
    localparam logic [3:0] IDX_UR = 4'd2;
    localparam logic [3:0] IDX_L  = 4'd3;
    localparam logic [3:0] IDX_C  = 4'd4;
    localparam logic [3:0] IDX_R  = 4'd5;
    localparam logic [3:0] IDX_DL = 4'd6;
    localparam logic [3:0] IDX_D  = 4'd7;
    localparam logic [3:0] IDX_DR = 4'd8;

    // Job timeline, counted in cycles after the start-acceptance cycle.
    localparam int N_READS       = 49;
    localparam int CYC_FETCH_END = 50;
    localparam int CYC_CALC_BEG  = 51;
    localparam int CYC_CALC_END  = 54;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CALC,
        ST_OUT
    } state_t;

endpackage

// File: rtl/hpel_interp_engine_tap6_filter.sv
// tap6_filter: combinational signed six-tap sum y = x0-5x1+20x2+20x3-5x4+x5.
// Ports: x[6] signed IN_W-bit samples, y signed OUT_W-bit sum.
// Purely combinational; OUT_W must be wide enough for the full tap gain.
module tap6_filter
    import hpel_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int OUT_W = 15
) (
    input  logic signed [IN_W-1:0]  x [6],
    output logic signed [OUT_W-1:0] y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < 6; i++) begin
            y = y + OUT_W'(x[i]) * OUT_W'(TAPS[i]);
        end
    end

endmodule

// File: rtl/hpel_interp_engine.sv
// hpel_interp_engine: fetches the 7x7 neighbourhood of a centre pixel and
// emits the 9 half-pel interpolated positions around it (idx 0..8).
// Ports: clk/rst (async active-low); start/center_addr job request;
// rd_en/rd_addr/rd_data window memory (1-cycle read latency);
// busy, pel_valid/pel_idx/pel_data result stream, done on the last beat.
module hpel_interp_engine
    import hpel_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int WIN_W  = 16,
    parameter int WIN_H  = 16,
    parameter int ADDR_W = $clog2(WIN_W * WIN_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] center_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              busy,
    output logic              pel_valid,
    output logic [3:0]        pel_idx,
    output logic [PIX_W-1:0]  pel_data,
    output logic              done
);

    localparam int CW = $clog2(WIN_W);
    localparam int RW = ADDR_W - CW;
    localparam int PW = PIX_W + 1;   // pixel as a non-negative signed value
    localparam int HW = PIX_W + 7;   // single-pass accumulator
    localparam int DW = PIX_W + 13;  // two-pass accumulator
    localparam logic signed [DW-1:0] PIX_MAX = DW'((1 << PIX_W) - 1);

    // Neighbour (r-3, k-3) of centre c, clamped so the edge pixel repeats.
    function automatic logic [ADDR_W-1:0] nbr_addr(input logic [ADDR_W-1:0] c,
                                                   input logic [2:0] r,
                                                   input logic [2:0] k);
        int y;
        int x;
        y = int'(c[ADDR_W-1:CW]) + int'(r) - 3;
        x = int'(c[CW-1:0]) + int'(k) - 3;
        if (y < 0) y = 0; else if (y > WIN_H - 1) y = WIN_H - 1;
        if (x < 0) x = 0; else if (x > WIN_W - 1) x = WIN_W - 1;
        return {RW'(y), CW'(x)};
    endfunction

    function automatic logic [PIX_W-1:0] clip(input logic signed [DW-1:0] v);
        if (v[DW-1])         return '0;
        else if (v > PIX_MAX) return '1;
        else                  return v[PIX_W-1:0];
    endfunction

    function automatic logic [PIX_W-1:0] round_h(input logic signed [HW-1:0] v);
        logic signed [HW-1:0] t;
        t = (v + HW'(RND_H)) >>> SH_H;
        return clip(DW'(t));
    endfunction

    function automatic logic [PIX_W-1:0] round_d(input logic signed [DW-1:0] v);
        return clip((v + DW'(RND_D)) >>> SH_D);
    endfunction

    state_t            state;
    logic [5:0]        cyc;        // cycles since acceptance
    logic [ADDR_W-1:0] cen;
    logic [2:0]        nr, nc;     // neighbourhood coords of the next read
    logic              data_vld;   // rd_data carries a fetched pixel this cycle
    logic [2:0]        dc;         // neighbourhood column of that pixel
    logic [1:0]        calc_k;

    logic [PIX_W-1:0]     rowbuf [6];  // first six pixels of the row in flight
    logic signed [HW-1:0] hm [7];      // horizontal -1/2 per row, unrounded
    logic signed [HW-1:0] hp [7];      // horizontal +1/2 per row, unrounded
    logic [PIX_W-1:0]     ctr [7];     // integer centre column per row
    logic [PIX_W-1:0]     res [9];

    logic signed [PW-1:0] hwin_m [6], hwin_p [6], vwin [6];
    logic signed [HW-1:0] dwin [6];
    logic signed [HW-1:0] h_m, h_p, v_sum;
    logic signed [DW-1:0] d_sum;

    assign calc_k = 2'(cyc - 6'(CYC_CALC_BEG));

    // The row's seventh pixel arrives on rd_data while rowbuf holds the other six,
    // so both horizontal half-pels of the row are ready on that beat.
    // In CALC, step k selects the vertical/diagonal source: k[0] picks -1/2 vs +1/2
    // horizontally (and upper vs lower vertical), k[1] the lower diagonal rows.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            hwin_m[i] = signed'({1'b0, rowbuf[i]});
            vwin[i]   = signed'({1'b0, ctr[3'(i) + {2'b00, calc_k[0]}]});
            dwin[i]   = calc_k[0] ? hp[3'(i) + {2'b00, calc_k[1]}]
                                  : hm[3'(i) + {2'b00, calc_k[1]}];
        end
        for (int i = 0; i < 5; i++) begin
            hwin_p[i] = signed'({1'b0, rowbuf[i+1]});
        end
        hwin_p[5] = signed'({1'b0, rd_data});
    end

    tap6_filter #(.IN_W(PW), .OUT_W(HW)) u_h_m (.x(hwin_m), .y(h_m));
    tap6_filter #(.IN_W(PW), .OUT_W(HW)) u_h_p (.x(hwin_p), .y(h_p));
    tap6_filter #(.IN_W(PW), .OUT_W(HW)) u_v   (.x(vwin),   .y(v_sum));
    tap6_filter #(.IN_W(HW), .OUT_W(DW)) u_d   (.x(dwin),   .y(d_sum));

    always_ff @(posedge clk) begin
        if (data_vld) begin
            for (int i = 0; i < 5; i++) rowbuf[i] <= rowbuf[i+1];
            rowbuf[5] <= rd_data;
            if (dc == 3'd6) begin
                for (int i = 0; i < 6; i++) begin
                    hm[i]  <= hm[i+1];
                    hp[i]  <= hp[i+1];
                    ctr[i] <= ctr[i+1];
                end
                hm[6]  <= h_m;
                hp[6]  <= h_p;
                ctr[6] <= rowbuf[3];
            end
        end
        if (state == ST_CALC) begin
            case (calc_k)
                2'd0: begin
                    res[IDX_UL] <= round_d(d_sum);
                    res[IDX_U]  <= round_h(v_sum);
                    res[IDX_L]  <= round_h(hm[3]);
                    res[IDX_C]  <= ctr[3];
                    res[IDX_R]  <= round_h(hp[3]);
                end
                2'd1: begin
                    res[IDX_UR] <= round_d(d_sum);
                    res[IDX_D]  <= round_h(v_sum);
                end
                2'd2:    res[IDX_DL] <= round_d(d_sum);
                default: res[IDX_DR] <= round_d(d_sum);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cyc       <= '0;
            cen       <= '0;
            nr        <= '0;
            nc        <= '0;
            dc        <= '0;
            data_vld  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            pel_valid <= 1'b0;
            pel_idx   <= '0;
            pel_data  <= '0;
        end else begin
            data_vld <= rd_en;
            if (data_vld) dc <= (dc == 3'd6) ? 3'd0 : dc + 3'd1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_FETCH;
                        cyc     <= 6'd1;
                        cen     <= center_addr;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= nbr_addr(center_addr, 3'd0, 3'd0);
                        nr      <= 3'd0;
                        nc      <= 3'd1;
                        dc      <= 3'd0;
                    end
                end
                ST_FETCH: begin
                    cyc <= cyc + 6'd1;
                    if (cyc < 6'(N_READS)) begin
                        rd_en   <= 1'b1;
                        rd_addr <= nbr_addr(cen, nr, nc);
                        if (nc == 3'd6) begin
                            nc <= 3'd0;
                            nr <= nr + 3'd1;
                        end else begin
                            nc <= nc + 3'd1;
                        end
                    end else begin
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                    end
                    if (cyc == 6'(CYC_FETCH_END)) state <= ST_CALC;
                end
                ST_CALC: begin
                    cyc <= cyc + 6'd1;
                    if (cyc == 6'(CYC_CALC_END)) begin
                        state     <= ST_OUT;
                        pel_valid <= 1'b1;
                        pel_idx   <= IDX_UL;
                        pel_data  <= res[IDX_UL];
                    end
                end
                default: begin
                    cyc <= cyc + 6'd1;
                    if (pel_idx == IDX_DR) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        pel_valid <= 1'b0;
                        pel_idx   <= '0;
                        pel_data  <= '0;
                    end else begin
                        pel_idx  <= pel_idx + 4'd1;
                        pel_data <= res[pel_idx + 4'd1];
                        done     <= (pel_idx == IDX_D);
                    end
                end
            endcase
        end
    end

endmodule
